mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage consuming the EX/MEM pipeline register outputs and producing the MEM/WB register. Performs data-RAM loads/stores over a req/ack handshake with variable latency, stalls upstream while an access is outstanding, selects write-back data, and registers the write-back bundle. Sits between the EX/MEM register and the register-file write port.

## Interface
- TIMEOUT_CYCLES, 16, cycles waited for `dram_ack` before abort (only with RAM_TIMEOUT_EN); range 1..255
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- wD_in  in  32  non-memory write-back value from EX/MEM
- wR_in  in  5  destination register
- rD2_in  in  32  store data
- pc_in  in  32  instruction PC
- aluc_in  in  32  ALU result, used as memory address
- have_inst_in  in  1  slot holds a valid instruction
- rf_wsel_in  in  2  write-back select; 2'b01 = load from RAM, else pass wD_in
- rf_we_in  in  1  register-file write enable
- ram_we_in  in  1  store request
- dram_req  out  1  memory request
- dram_we  out  1  1 = store, 0 = load
- dram_addr  out  32  byte address (= aluc_in)
- dram_wdata  out  32  store data (= rD2_in)
- dram_ack  in  1  access complete; rdata valid same cycle for loads
- dram_rdata  in  32  load data
- stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- wD_out  out  32  write-back data to MEM/WB
- wR_out  out  5  registered wR
- rf_we_out  out  1  registered write enable
- pc_out  out  32  registered PC
- have_inst_out  out  1  registered valid
- mem_err  out  1  one-cycle timeout pulse (RAM_TIMEOUT_EN only; tied 0 otherwise)

## Operation
- access = have_inst_in & (ram_we_in | rf_wsel_in==2'b01). Store wins dram_we if both set.
- FSM states IDLE, WAIT. IDLE: if access, drive dram_req=1 combinationally; ack same cycle -> retire, stay IDLE; no ack -> WAIT. WAIT: hold dram_req=1, addr/we/wdata unchanged (upstream frozen); ack -> retire, IDLE.
- stall_out = access & ~dram_ack (combinational, both states).
- Retire (no stall): output register latches wR_in, pc_in, have_inst_in, rf_we_in; wD_out = dram_rdata if rf_wsel_in==2'b01 else wD_in.
- Stalled cycle: output register loads bubble: have_inst_out=0, rf_we_out=0, wR_out=0, wD_out=0, pc_out=0. No instruction retires twice.
- dram_ack while dram_req=0: ignored.
- Non-access instructions: never stall, no bus activity.

## Timing
- Reset (async): state IDLE, all registered outputs 0, mem_err 0, timeout counter 0; dram_req drops on assertion because state forced IDLE (and have_inst gating from upstream reset). Reset mid-WAIT abandons the access; nothing retires.
- Latency: non-access and zero-wait access -> outputs valid 1 cycle after the instruction appears. Ack k cycles after first request -> stall_out high k cycles, retire on edge after ack cycle.
- Back-to-back accesses: new request may assert the cycle after retire; no dead cycle.
- Address/data alignment not checked; passed through.

## Configuration
- RAM_TIMEOUT_EN defined: 8-bit counter increments each WAIT cycle, clears on entering IDLE. When count reaches TIMEOUT_CYCLES with no ack: dram_req drops, mem_err pulses 1 cycle, instruction retires with rf_we_out=0 (have_inst_out=1, pc_out kept), stall released, state IDLE. Ack on the timeout cycle wins over timeout.
- Undefined: no counter, WAIT indefinitely, mem_err constant 0.

## Test plan
- ALU op, have_inst_in=1, rf_wsel_in=00, wD_in=0x1234, wR_in=5, rf_we_in=1 -> next edge wD_out=0x1234, wR_out=5, rf_we_out=1; stall_out never 1.
- Load aluc_in=0x100, dram_ack same cycle, dram_rdata=0xDEADBEEF -> dram_req=1, dram_we=0, stall_out=0, next edge wD_out=0xDEADBEEF.
- Store aluc_in=0x20, rD2_in=0xA5A5A5A5, ack after 3 cycles -> stall_out high 3 cycles, dram_wdata stable, 3 bubbles (rf_we_out=0, have_inst_out=0), then have_inst_out=1 for one cycle.
- Load waiting, rst pulsed in WAIT -> all outputs 0, dram_req 0 immediately, state IDLE; later ack ignored.
- RAM_TIMEOUT_EN, TIMEOUT_CYCLES=4, load never acked -> after 4 WAIT cycles mem_err=1 one cycle, rf_we_out=0, have_inst_out=1, stall_out=0 next cycle.
- Spurious dram_ack=1 with no access -> no state change, outputs follow non-access path.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: data-RAM req/ack access, upstream stall, MEM/WB register.
// Optional RAM_TIMEOUT_EN aborts an unacknowledged access after TIMEOUT_CYCLES wait cycles.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wD_in,
    input  logic [4:0]  wR_in,
    input  logic [31:0] rD2_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] aluc_in,
    input  logic        have_inst_in,
    input  logic [1:0]  rf_wsel_in,
    input  logic        rf_we_in,
    input  logic        ram_we_in,
    output logic        dram_req,
    output logic        dram_we,
    output logic [31:0] dram_addr,
    output logic [31:0] dram_wdata,
    input  logic        dram_ack,
    input  logic [31:0] dram_rdata,
    output logic        stall_out,
    output logic [31:0] wD_out,
    output logic [4:0]  wR_out,
    output logic        rf_we_out,
    output logic [31:0] pc_out,
    output logic        have_inst_out,
    output logic        mem_err,
    output logic        state_dbg
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    // Handshake: dram_req stays high from the first request cycle until the
    // cycle dram_ack is seen; address/data/we are stable because upstream is
    // frozen by stall_out. dram_ack while dram_req is low has no effect.

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_t state_q, state_d;
    logic   access;
    logic   is_load;
    logic   timeout_hit;

    assign is_load = (rf_wsel_in == 2'b01);
    assign access  = have_inst_in & (ram_we_in | is_load);

`ifdef RAM_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       mem_err_q;

    assign timeout_hit = (state_q == WAIT) & ~dram_ack & (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q     <= (state_q == WAIT && state_d == WAIT) ? cnt_q + 8'd1 : 8'd0;
            mem_err_q <= timeout_hit;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        dram_req  = 1'b0;
        dram_we   = 1'b0;
        stall_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    dram_req  = 1'b1;
                    dram_we   = ram_we_in;
                    stall_out = ~dram_ack;
                    if (!dram_ack) state_d = WAIT;
                end
            end
            WAIT: begin
                if (access && !timeout_hit) begin
                    dram_req  = 1'b1;
                    dram_we   = ram_we_in;
                    stall_out = ~dram_ack;
                end
                if (dram_ack || timeout_hit || !access) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dram_addr  = aluc_in;
    assign dram_wdata = rD2_in;
    assign state_dbg  = state_q;

    // A stalled cycle loads a bubble so the waiting instruction retires exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wD_out        <= 32'd0;
            wR_out        <= 5'd0;
            rf_we_out     <= 1'b0;
            pc_out        <= 32'd0;
            have_inst_out <= 1'b0;
        end else if (stall_out) begin
            wD_out        <= 32'd0;
            wR_out        <= 5'd0;
            rf_we_out     <= 1'b0;
            pc_out        <= 32'd0;
            have_inst_out <= 1'b0;
        end else begin
            wD_out        <= is_load ? dram_rdata : wD_in;
            wR_out        <= wR_in;
            rf_we_out     <= rf_we_in & ~timeout_hit;
            pc_out        <= pc_in;
            have_inst_out <= have_inst_in;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (ALU, load, waited store,
// reset during WAIT, spurious ack; timeout case when RAM_TIMEOUT_EN is defined).
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wD_in, rD2_in, pc_in, aluc_in, dram_rdata;
    logic [4:0]  wR_in;
    logic        have_inst_in, rf_we_in, ram_we_in, dram_ack;
    logic [1:0]  rf_wsel_in;
    logic        dram_req, dram_we, stall_out, rf_we_out, have_inst_out, mem_err, state_dbg;
    logic [31:0] dram_addr, dram_wdata, wD_out, pc_out;
    logic [4:0]  wR_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .wD_in(wD_in), .wR_in(wR_in), .rD2_in(rD2_in), .pc_in(pc_in), .aluc_in(aluc_in),
        .have_inst_in(have_inst_in), .rf_wsel_in(rf_wsel_in), .rf_we_in(rf_we_in),
        .ram_we_in(ram_we_in),
        .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
        .dram_ack(dram_ack), .dram_rdata(dram_rdata),
        .stall_out(stall_out), .wD_out(wD_out), .wR_out(wR_out), .rf_we_out(rf_we_out),
        .pc_out(pc_out), .have_inst_out(have_inst_out), .mem_err(mem_err), .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic have, input logic [1:0] wsel, input logic rfwe,
                         input logic ramwe, input logic [31:0] wd, input logic [4:0] wr,
                         input logic [31:0] pc, input logic [31:0] aluc, input logic [31:0] rd2);
        have_inst_in = have; rf_wsel_in = wsel; rf_we_in = rfwe; ram_we_in = ramwe;
        wD_in = wd; wR_in = wr; pc_in = pc; aluc_in = aluc; rD2_in = rd2;
    endtask

    // Advance one clock; return 1 ns after the edge so registered outputs are settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        dram_ack = 1'b0; dram_rdata = 32'd0;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        step(); step();
        check("rst_wD", wD_out, 32'd0);
        check("rst_have", {31'd0, have_inst_out}, 32'd0);
        check("rst_req", {31'd0, dram_req}, 32'd0);
        check("rst_state", {31'd0, state_dbg}, 32'd0);
        rst = 1'b0;

        // ALU op: no bus activity, retires next edge
        drive(1'b1, 2'b00, 1'b1, 1'b0, 32'h1234, 5'd5, 32'h40, 32'h999, 32'h0);
        #3;
        check("alu_stall", {31'd0, stall_out}, 32'd0);
        check("alu_req", {31'd0, dram_req}, 32'd0);
        step();
        check("alu_wD", wD_out, 32'h1234);
        check("alu_wR", {27'd0, wR_out}, 32'd5);
        check("alu_we", {31'd0, rf_we_out}, 32'd1);
        check("alu_pc", pc_out, 32'h40);

        // Load acknowledged in the same cycle
        drive(1'b1, 2'b01, 1'b1, 1'b0, 32'h5555, 5'd7, 32'h44, 32'h100, 32'h0);
        dram_ack = 1'b1; dram_rdata = 32'hDEADBEEF;
        #3;
        check("ld_req", {31'd0, dram_req}, 32'd1);
        check("ld_we", {31'd0, dram_we}, 32'd0);
        check("ld_addr", dram_addr, 32'h100);
        check("ld_stall", {31'd0, stall_out}, 32'd0);
        step();
        check("ld_wD", wD_out, 32'hDEADBEEF);
        check("ld_wR", {27'd0, wR_out}, 32'd7);

        // Store acknowledged after 3 wait cycles
        drive(1'b1, 2'b00, 1'b0, 1'b1, 32'h0, 5'd0, 32'h48, 32'h20, 32'hA5A5A5A5);
        dram_ack = 1'b0; dram_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #3;
            check($sformatf("st_stall%0d", i), {31'd0, stall_out}, 32'd1);
            check($sformatf("st_req%0d", i), {31'd0, dram_req}, 32'd1);
            check($sformatf("st_dwe%0d", i), {31'd0, dram_we}, 32'd1);
            check($sformatf("st_wdata%0d", i), dram_wdata, 32'hA5A5A5A5);
            step();
            check($sformatf("st_bub_have%0d", i), {31'd0, have_inst_out}, 32'd0);
            check($sformatf("st_bub_we%0d", i), {31'd0, rf_we_out}, 32'd0);
            check($sformatf("st_state%0d", i), {31'd0, state_dbg}, 32'd1);
        end
        dram_ack = 1'b1;
        #3;
        check("st_ack_stall", {31'd0, stall_out}, 32'd0);
        step();
        check("st_ret_have", {31'd0, have_inst_out}, 32'd1);
        check("st_ret_pc", pc_out, 32'h48);
        check("st_idle", {31'd0, state_dbg}, 32'd0);

        // Back-to-back load right after the store retires, ack same cycle
        drive(1'b1, 2'b01, 1'b1, 1'b0, 32'h0, 5'd9, 32'h4C, 32'h200, 32'h0);
        dram_rdata = 32'hCAFEF00D;
        #3;
        check("b2b_req", {31'd0, dram_req}, 32'd1);
        step();
        check("b2b_wD", wD_out, 32'hCAFEF00D);
        check("b2b_have", {31'd0, have_inst_out}, 32'd1);

        // Load stuck in WAIT, then reset (upstream reset also clears have_inst)
        drive(1'b1, 2'b01, 1'b1, 1'b0, 32'h0, 5'd3, 32'h50, 32'h300, 32'h0);
        dram_ack = 1'b0;
        step();
        check("rw_state", {31'd0, state_dbg}, 32'd1);
        check("rw_stall", {31'd0, stall_out}, 32'd1);
        rst = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0);
        #1;
        check("rw_req", {31'd0, dram_req}, 32'd0);
        check("rw_state0", {31'd0, state_dbg}, 32'd0);
        check("rw_have", {31'd0, have_inst_out}, 32'd0);
        check("rw_pc", pc_out, 32'd0);
        #2;
        rst = 1'b0;
        dram_ack = 1'b1;
        step();
        check("rw_late_ack_have", {31'd0, have_inst_out}, 32'd0);
        check("rw_late_ack_state", {31'd0, state_dbg}, 32'd0);

        // Spurious ack with a non-access instruction
        drive(1'b1, 2'b10, 1'b1, 1'b0, 32'h0BADC0DE, 5'd31, 32'h60, 32'h0, 32'h0);
        dram_rdata = 32'hFFFFFFFF;
        #3;
        check("sp_req", {31'd0, dram_req}, 32'd0);
        check("sp_stall", {31'd0, stall_out}, 32'd0);
        step();
        check("sp_wD", wD_out, 32'h0BADC0DE);
        check("sp_wR", {27'd0, wR_out}, 32'd31);
        check("sp_state", {31'd0, state_dbg}, 32'd0);
        check("sp_err", {31'd0, mem_err}, 32'd0);
        dram_ack = 1'b0;

`ifdef RAM_TIMEOUT_EN
        // Load never acknowledged: aborts on the 4th WAIT cycle
        drive(1'b1, 2'b01, 1'b1, 1'b0, 32'h0, 5'd2, 32'h70, 32'h400, 32'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("to_stall%0d", i), {31'd0, stall_out}, 32'd1);
            check($sformatf("to_err%0d", i), {31'd0, mem_err}, 32'd0);
            step();
        end
        #3;
        check("to_stall_rel", {31'd0, stall_out}, 32'd0);
        check("to_req_drop", {31'd0, dram_req}, 32'd0);
        step();
        check("to_err", {31'd0, mem_err}, 32'd1);
        check("to_have", {31'd0, have_inst_out}, 32'd1);
        check("to_we", {31'd0, rf_we_out}, 32'd0);
        check("to_pc", pc_out, 32'h70);
        check("to_state", {31'd0, state_dbg}, 32'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0);
        step();
        check("to_err_pulse", {31'd0, mem_err}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
